// File: rtl/axi_lite_ram.sv
// AXI4-Lite slave backed by a single-port 32-bit word RAM with independent read/write FSMs.
// Define AXI_LITE_RAM_WSTRB_EN to honour per-byte write strobes; otherwise whole words are written.
module axi_lite_ram #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        rready
);

    localparam int unsigned Depth     = 2 ** DEPTH_LOG2;
    localparam logic [32:0] SpanBytes = 33'(Depth) << 2;

    typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_e;

    w_state_e w_state, w_state_d;
    r_state_e r_state, r_state_d;

    logic        aw_got, aw_got_d;
    logic        w_got, w_got_d;
    logic [31:0] aw_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic [31:0] ar_addr;

    logic [31:0] mem [Depth];

    logic aw_hs, w_hs, ar_hs, r_hs, b_hs;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;
    assign b_hs  = bvalid & bready;

    // Bit 32 of the difference is the borrow, i.e. the address lies below BASE_ADDR.
    logic [32:0]           aw_diff, ar_diff;
    logic                  aw_in_range, ar_in_range;
    logic [DEPTH_LOG2-1:0] aw_idx, ar_idx;

    assign aw_diff     = {1'b0, aw_addr} - {1'b0, BASE_ADDR};
    assign ar_diff     = {1'b0, ar_addr} - {1'b0, BASE_ADDR};
    assign aw_in_range = !aw_diff[32] && ({1'b0, aw_diff[31:0]} < SpanBytes);
    assign ar_in_range = !ar_diff[32] && ({1'b0, ar_diff[31:0]} < SpanBytes);
    assign aw_idx      = aw_diff[DEPTH_LOG2+1:2];
    assign ar_idx      = ar_diff[DEPTH_LOG2+1:2];

    logic unused_bits;
    assign unused_bits = ^{awprot, arprot, w_strb, aw_diff, ar_diff};

    always_comb begin
        r_state_d = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_d = R_READ;
            R_READ:  r_state_d = R_RESP;
            R_RESP:  if (r_hs) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase

        aw_got_d = (w_state == W_COMMIT) ? 1'b0 : (aw_got | aw_hs);
        w_got_d  = (w_state == W_COMMIT) ? 1'b0 : (w_got | w_hs);

        // A read entering R_READ owns the RAM port; the write commits a cycle later.
        w_state_d = w_state;
        case (w_state)
            W_COLLECT: if (aw_got_d && w_got_d && (r_state_d != R_READ)) w_state_d = W_COMMIT;
            W_COMMIT:  w_state_d = W_RESP;
            W_RESP:    if (b_hs) w_state_d = W_COLLECT;
            default:   w_state_d = W_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state <= W_COLLECT;
            r_state <= R_IDLE;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            arready <= 1'b0;
            bvalid  <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            w_state <= w_state_d;
            r_state <= r_state_d;
            aw_got  <= aw_got_d;
            w_got   <= w_got_d;
            awready <= (w_state_d == W_COLLECT) && !aw_got_d;
            wready  <= (w_state_d == W_COLLECT) && !w_got_d;
            arready <= (r_state_d == R_IDLE) && (w_state_d != W_COMMIT);
            bvalid  <= (w_state_d == W_RESP);
            rvalid  <= (r_state_d == R_RESP);
            if (aw_hs) aw_addr <= awaddr;
            if (w_hs) begin
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (ar_hs) ar_addr <= araddr;
            if (r_state == R_READ) rdata <= ar_in_range ? mem[ar_idx] : 32'h0;
        end
    end

    // RAM is never reset; a reset landing on W_COMMIT cancels the write.
    always_ff @(posedge clk) begin
        if (rstn && (w_state == W_COMMIT) && aw_in_range) begin
`ifdef AXI_LITE_RAM_WSTRB_EN
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
            end
`else
            mem[aw_idx] <= w_data;
`endif
        end
    end

endmodule

// File: tb/tb_axi_lite_ram.sv
// Self-checking bench for axi_lite_ram: directed vector table plus hand-written timing sequences.
module tb_axi_lite_ram;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;

    axi_lite_ram dut (
        .clk(clk), .rstn(rstn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

`ifdef AXI_LITE_RAM_WSTRB_EN
    localparam logic [31:0] ExpStrb5 = 32'h11BB33DD;
    localparam logic [31:0] ExpStrb0 = 32'hCAFEF00D;
`else
    localparam logic [31:0] ExpStrb5 = 32'hAABBCCDD;
    localparam logic [31:0] ExpStrb0 = 32'h55667788;
`endif

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    localparam int NumVecs = 17;
    vec_t vecs [NumVecs];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // lat counts edges from the handshake edge (1) to the first sample showing bvalid.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int lat);
        bit aw_fire, w_fire;
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        lat = -1;
        for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick();
            if (aw_fire) awvalid = 1'b0;
            if (w_fire) wvalid = 1'b0;
        end
        if (awvalid || wvalid) begin
            awvalid = 1'b0;
            wvalid  = 1'b0;
            return;
        end
        n = 1;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        if (bvalid) begin
            lat = n;
            tick();
        end
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        bit fire;
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        lat = -1;
        d = 32'hxxxx_xxxx;
        for (int i = 0; i < 20 && arvalid; i++) begin
            fire = arready;
            tick();
            if (fire) arvalid = 1'b0;
        end
        if (arvalid) begin
            arvalid = 1'b0;
            return;
        end
        n = 1;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        if (rvalid) begin
            lat = n;
            d = rdata;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, bn, rn;
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 32'h0000_0000, 32'hA5A5_0001, 4'hF, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 4'hF, 32'h0};
        vecs[2]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[3]  = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hA5A5_0001};
        vecs[5]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0BAD_F00D};
        vecs[6]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0000_0000};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0000_0000};
        vecs[8]  = '{1'b1, 32'h0000_0044, 32'h1122_3344, 4'hF, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_0046, 32'hAABB_CCDD, 4'h5, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0045, 32'h0,         4'h0, ExpStrb5};
        vecs[11] = '{1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4'hF, 32'h0};
        vecs[12] = '{1'b1, 32'h0000_0080, 32'h5566_7788, 4'h0, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_0082, 32'h0,         4'h0, ExpStrb0};
        vecs[14] = '{1'b1, 32'h0000_0800, 32'h1212_1212, 4'hF, 32'h0};
        vecs[15] = '{1'b0, 32'h0000_0800, 32'h0,         4'h0, 32'h1212_1212};
        vecs[16] = '{1'b0, 32'h0000_0003, 32'h0,         4'h0, 32'hA5A5_0001};

        rstn = 1'b0;
        awaddr = '0; wdata = '0; wstrb = 4'hF; araddr = '0;
        awprot = 3'b000; arprot = 3'b000;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_awready", 64'(awready), 64'h0);
        check("rst_wready", 64'(wready), 64'h0);
        check("rst_arready", 64'(arready), 64'h0);
        check("rst_bvalid", 64'(bvalid), 64'h0);
        check("rst_rvalid", 64'(rvalid), 64'h0);
        check("rst_rdata", 64'(rdata), 64'h0);
        rstn = 1'b1;
        tick();
        check("rel_ready", 64'({awready, wready, arready, bvalid, rvalid}), 64'b11100);

        // AW and W in the same cycle
        axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, lat);
        check("same_cycle_b_lat", 64'(lat), 64'd2);
        axi_read(32'h10, rd, lat);
        check("same_cycle_rdata", 64'(rd), 64'hDEAD_BEEF);
        check("same_cycle_r_lat", 64'(lat), 64'd2);

        // W three cycles ahead of AW
        check("wfirst_wready", 64'(wready), 64'h1);
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        tick();
        wvalid = 1'b0;
        check("wfirst_wready_low", 64'({wready, awready}), 64'b01);
        tick();
        check("wfirst_wait", 64'({wready, bvalid}), 64'b00);
        tick();
        awaddr = 32'h20; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst_commit", 64'({bvalid, awready, wready}), 64'b000);
        tick();
        check("wfirst_bvalid", 64'(bvalid), 64'h1);
        tick();
        axi_read(32'h20, rd, lat);
        check("wfirst_rdata", 64'(rd), 64'h1234_5678);

        // Vector table
        for (int i = 0; i < NumVecs; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, lat);
                check($sformatf("vec%0d_b_lat", i), 64'(lat), 64'd2);
            end else begin
                axi_read(vecs[i].addr, rd, lat);
                check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp));
                check($sformatf("vec%0d_r_lat", i), 64'(lat), 64'd2);
            end
        end

        // Write eligibility coinciding with an AR handshake: read goes first
        axi_write(32'h100, 32'h0101_0101, 4'hF, lat);
        check("coll_ready", 64'({awready, wready, arready}), 64'b111);
        awaddr = 32'h100; wdata = 32'h0202_0202; wstrb = 4'hF; araddr = 32'h100;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        bn = -1; rn = -1; rd = '0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (n == 1) begin
                awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
            end
            if (bvalid && bn < 0) bn = n;
            if (rvalid && rn < 0) begin
                rn = n;
                rd = rdata;
            end
        end
        check("coll_r_lat", 64'(rn), 64'd2);
        check("coll_b_lat", 64'(bn), 64'd3);
        check("coll_old_data", 64'(rd), 64'h0101_0101);
        axi_read(32'h100, rd, lat);
        check("coll_new_data", 64'(rd), 64'h0202_0202);

        // rready held low: response stable, no new AR accepted
        araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
        check("stall_arready", 64'(arready), 64'h1);
        tick();
        araddr = 32'h20;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_hold%0d", i), 64'({rvalid, arready, rdata}),
                  64'({1'b1, 1'b0, 32'hDEAD_BEEF}));
            tick();
        end
        rready = 1'b1;
        tick();
        arvalid = 1'b0;
        axi_read(32'h20, rd, lat);
        check("stall_next_read", 64'(rd), 64'h1234_5678);

        // Reset during W_RESP keeps the committed word
        axi_write(32'h200, 32'h7777_7777, 4'hF, lat);
        awaddr = 32'h200; wdata = 32'h8888_8888; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("resp_bvalid", 64'(bvalid), 64'h1);
        rstn = 1'b0;
        tick();
        check("resp_rst_bvalid", 64'({bvalid, awready, wready}), 64'b000);
        rstn = 1'b1;
        tick();
        check("resp_rel_ready", 64'({awready, wready, arready}), 64'b111);
        axi_read(32'h200, rd, lat);
        check("resp_rst_data", 64'(rd), 64'h8888_8888);

        // Reset landing on W_COMMIT cancels the write
        awaddr = 32'h200; wdata = 32'hAAAA_0000; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        axi_read(32'h200, rd, lat);
        check("commit_rst_data", 64'(rd), 64'h8888_8888);

        // Reset with only W collected clears the flag
        wdata = 32'h9999_9999; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("wonly_wready_low", 64'(wready), 64'h0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        check("wonly_rel_wready", 64'(wready), 64'h1);
        axi_read(32'h200, rd, lat);
        check("wonly_data", 64'(rd), 64'h8888_8888);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_ram.md
AXI_LITE_RAM -- requirements
Module: axi_lite_ram

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of RAM depth in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 awaddr  input  32  write byte address.
REQ-006 awprot  input  3  ignored.
REQ-007 awvalid  input  1  write address valid.
REQ-008 awready  output  1  write address accepted.
REQ-009 wdata  input  32  write data.
REQ-010 wstrb  input  4  byte lane enables; bit i selects wdata[8i+7:8i].
REQ-011 wvalid  input  1  write data valid.
REQ-012 wready  output  1  write data accepted.
REQ-013 bvalid  output  1  write response valid.
REQ-014 bready  input  1  write response accepted.
REQ-015 araddr  input  32  read byte address.
REQ-016 arprot  input  3  ignored.
REQ-017 arvalid  input  1  read address valid.
REQ-018 arready  output  1  read address accepted.
REQ-019 rdata  output  32  read data.
REQ-020 rvalid  output  1  read data valid.
REQ-021 rready  input  1  read data accepted.

Function
REQ-022 SHALL hold 2^DEPTH_LOG2 32-bit words; word index = (addr - BASE_ADDR)[DEPTH_LOG2+1:2]; addr[1:0] ignored.
REQ-023 Address in range SHALL mean BASE_ADDR <= addr < BASE_ADDR + 4*2^DEPTH_LOG2; out-of-range writes SHALL be dropped and out-of-range reads SHALL return 32'h0, with normal handshakes.
REQ-024 Write FSM SHALL have states W_COLLECT, W_COMMIT, W_RESP; reset state W_COLLECT with flags aw_got=w_got=0.
REQ-025 In W_COLLECT: awready = ~aw_got, wready = ~w_got; each handshake latches its payload and sets its flag; AW and W accepted in either order or same cycle.
REQ-026 W_COLLECT -> W_COMMIT on the first cycle both flags are set and read FSM is not in R_READ; otherwise stay.
REQ-027 W_COMMIT SHALL last exactly one cycle, write RAM, clear flags, go to W_RESP.
REQ-028 W_RESP SHALL assert bvalid, hold until bready, then return to W_COLLECT; awready=wready=0 in W_COMMIT and W_RESP.
REQ-029 Read FSM SHALL have states R_IDLE, R_READ, R_RESP; reset state R_IDLE.
REQ-030 arready SHALL be 1 only in R_IDLE while write FSM is not in W_COMMIT; handshake latches araddr, goes to R_READ.
REQ-031 R_READ SHALL last one cycle, register RAM word into rdata, go to R_RESP; rvalid first asserted 2 cycles after AR handshake.
REQ-032 R_RESP SHALL hold rvalid and rdata stable until rready, then return to R_IDLE; no new AR accepted in R_READ/R_RESP.
REQ-033 Single RAM port: W_COMMIT and R_READ SHALL never coincide; if both become eligible the same cycle, the read wins and the write commits one cycle later.
REQ-034 Write-then-read to the same address SHALL return the new data when the AR handshake follows bvalid.

Reset
REQ-035 While rstn=0 at a clock edge, both FSMs SHALL go to reset state, flags clear, awready=wready=arready=bvalid=rvalid=0, rdata=32'h0.
REQ-036 RAM contents SHALL not be reset; reset mid-transaction SHALL abandon it without a RAM write unless W_COMMIT already completed.
REQ-037 First cycle after reset release SHALL drive awready=wready=arready=1.

Configuration
REQ-038 With AXI_LITE_RAM_WSTRB_EN defined, only bytes whose wstrb bit is 1 SHALL be written; wstrb=4'b0000 writes nothing but still responds.
REQ-039 Without AXI_LITE_RAM_WSTRB_EN, wstrb SHALL be ignored and all 4 bytes written.

Verification
REQ-040 AW 0x10 + W 0xDEADBEEF same cycle, bready=1 -> bvalid 2 cycles after handshake; read 0x10 -> rdata 0xDEADBEEF, rvalid 2 cycles after AR.
REQ-041 W 0x12345678 three cycles before AW 0x20 -> wready low after W handshake, single write at AW+1 cycle; read returns 0x12345678.
REQ-042 Macro defined: word 0x11223344, write 0xAABBCCDD wstrb 4'b0101 -> reads 0x11BB33DD; macro undefined -> reads 0xAABBCCDD.
REQ-043 Both flags set same cycle as AR handshake -> R_READ first, W_COMMIT next cycle; no RAM port conflict asserted by bench.
REQ-044 rready=0 for 5 cycles -> rvalid, rdata stable; arready=0 throughout; read address BASE_ADDR+0x1000 (DEPTH_LOG2=10) -> rdata 0x0.
REQ-045 rstn low during W_RESP -> bvalid=0 next edge, target word unchanged if reset hit before W_COMMIT.
